// File: rtl/phrase_sequencer.sv
// Queues clip IDs and plays them back-to-back through the audio controller.
// Ports: push/push_id/abort in; full/empty/tbl_id, start/end addr, silent, start, busy, err out.
module phrase_sequencer #(
  parameter int DEPTH      = 16,
  parameter int ID_W       = 5,
  parameter int SILENCE_ID = 0,
  parameter int ACK_TOUT   = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            abort,
  output logic            full,
  output logic            empty,
  output logic [ID_W-1:0] tbl_id,
  input  logic [23:0]     tbl_start,
  input  logic [23:0]     tbl_end,
  output logic [23:0]     start_address,
  output logic [23:0]     end_address,
  output logic            silent,
  output logic            start,
  input  logic            finish,
  output logic            busy,
  output logic            err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TOUT + 1);
  localparam logic [ID_W-1:0] SIL = ID_W'(SILENCE_ID);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_ACK,
    S_PLAY
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [23:0]     sa_q, sa_d;
  logic [23:0]     ea_q, ea_d;
  logic            sil_q, sil_d;
  logic            fire_q, fire_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            err_q, err_d;
  logic            pop;
  logic            push_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign tbl_id  = mem_q[rd_q];
  assign push_ok = push & ~full & ~abort;

  assign start_address = sa_q;
  assign end_address   = ea_q;
  assign silent        = sil_q;
  assign err           = err_q;
  assign start         = (state_q == S_FIRE) & ~abort;
  assign busy          = (state_q != S_IDLE) | ~empty;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    ea_d    = ea_q;
    sil_d   = sil_q;
    fire_d  = fire_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        sa_d    = tbl_start;
        ea_d    = tbl_end;
        sil_d   = (tbl_id == SIL);
        pop     = 1'b1;
        fire_d  = 1'b0;
        state_d = S_FIRE;
      end
      S_FIRE: begin
        // fire_q marks the second of the two start cycles
        tmr_d  = '0;
        fire_d = ~fire_q;
        if (fire_q) state_d = S_ACK;
      end
      S_ACK: begin
        if (!finish) begin
          state_d = S_PLAY;
        end else if (tmr_q == TW'(ACK_TOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_PLAY: begin
        if (finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      sa_d    = sa_q;
      ea_d    = ea_q;
      sil_d   = sil_q;
      err_d   = err_q;
      fire_d  = 1'b0;
      pop     = 1'b0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = push_id;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (abort) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      sa_q    <= '0;
      ea_q    <= '0;
      sil_q   <= 1'b0;
      fire_q  <= 1'b0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      ea_q    <= ea_d;
      sil_q   <= sil_d;
      fire_q  <= fire_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_phrase_sequencer.sv
// Scoreboard bench for phrase_sequencer with a small audio-controller model.
// Expected clips are queued at push time and compared against observed start pulses.
module tb_phrase_sequencer;

  localparam int ACK_TOUT = 255;

  typedef struct packed {
    logic [23:0] sa;
    logic [23:0] ea;
    logic        sil;
  } clip_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic [4:0]  push_id = '0;
  logic        abort = 1'b0;
  logic        full, empty, silent, start, busy, err;
  logic [4:0]  tbl_id;
  logic [23:0] tbl_start, tbl_end, start_address, end_address;
  logic        finish;
  clip_t       rom_c;

  phrase_sequencer dut (
    .clk(clk), .reset(reset), .push(push), .push_id(push_id),
    .abort(abort), .full(full), .empty(empty), .tbl_id(tbl_id),
    .tbl_start(tbl_start), .tbl_end(tbl_end),
    .start_address(start_address), .end_address(end_address),
    .silent(silent), .start(start), .finish(finish),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic clip_t rom(input logic [4:0] id);
    clip_t c;
    c.sa  = 24'(id) << 12;
    c.ea  = c.sa + 24'(id);
    c.sil = (id == 5'd0);
    if (id == 5'd3) begin c.sa = 24'h000100; c.ea = 24'h0001FF; end
    if (id == 5'd7) begin c.sa = 24'h000400; c.ea = 24'h00043F; end
    return c;
  endfunction

  assign rom_c     = rom(tbl_id);
  assign tbl_start = rom_c.sa;
  assign tbl_end   = rom_c.ea;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mode = 0;
  clip_t exp_q[$];
  clip_t obs_q[$];
  int wid_q[$];
  int gap_q[$];
  int rise_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // audio controller: finish drops one cycle after start, stays low 5 cycles
  initial begin
    int dly, lowc;
    logic mst, nf;
    dly = 0; lowc = 0; mst = 1'b0;
    finish = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        dly = 0; lowc = 0; mst = 1'b0; finish = 1'b1;
      end else begin
        nf = 1'b1;
        if (start && !mst) begin dly = 1; lowc = 5; end
        else if (dly > 0) dly--;
        else if (lowc > 0) begin lowc--; nf = 1'b0; end
        mst = start;
        finish = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : nf;
      end
    end
  end

  initial begin
    logic pst, pfin;
    int run, last_fin;
    pst = 1'b0; pfin = 1'b1; run = 0; last_fin = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pst = 1'b0; pfin = 1'b1; run = 0;
      end else begin
        if (start && !pst) begin
          obs_q.push_back({start_address, end_address, silent});
          gap_q.push_back(cyc - last_fin);
          rise_q.push_back(cyc);
        end
        if (start) run++;
        else if (pst) begin wid_q.push_back(run); run = 0; end
        if (finish && !pfin) last_fin = cyc;
        pst = start;
        pfin = finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    exp_q.delete(); obs_q.delete(); wid_q.delete();
    gap_q.delete(); rise_q.delete();
  endtask

  task automatic push1(input logic [4:0] id, input bit keep);
    push = 1'b1;
    push_id = id;
    if (keep) exp_q.push_back(rom(id));
    tick(1);
    push = 1'b0;
  endtask

  task automatic wait_wid(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wid_q.size() >= n) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; push = 1'b0; abort = 1'b0; mode = 0;
    tick(2);
    reset = 1'b1;
    clear_q();
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full got %b want 0", full); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %b want 1", empty); end
    tests++; if (tbl_id !== 5'd0) begin fails++; $display("FAIL rst_tbl_id got %h want 0", tbl_id); end
    tests++; if (start_address !== 24'd0) begin fails++; $display("FAIL rst_sa got %h want 0", start_address); end
    tests++; if (end_address !== 24'd0) begin fails++; $display("FAIL rst_ea got %h want 0", end_address); end
    tests++; if (silent !== 1'b0) begin fails++; $display("FAIL rst_silent got %b want 0", silent); end
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL rst_start got %b want 0", start); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", err); end
    reset = 1'b1;
    clear_q();
    tick(2);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_two_clips();
    bit ok;
    clip_t e, o;
    int w;
    push1(5'd3, 1'b1);
    push1(5'd7, 1'b1);
    wait_wid(2, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL two_timeout got %0d pulses want 2", wid_q.size()); end
    tests++; if (gap_q.size() > 1 && gap_q[1] !== 3) begin fails++; $display("FAIL two_gap got %0d want 3", gap_q[1]); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL two_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0 && wid_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); w = wid_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL two_clip got %h want %h", o, e); end
      tests++; if (w !== 2) begin fails++; $display("FAIL two_width got %0d want 2", w); end
    end
    tick(20);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL two_idle busy got %b want 0", busy); end
    clear_q();
  endtask

  task automatic test_full();
    bit ok;
    clip_t e, o;
    int w;
    mode = 1;
    push1(5'd1, 1'b1);
    wait_wid(1, 50, ok);
    tick(3);
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL full_pre got %b want 0", full); end
    for (int i = 0; i < 16; i++) push1(5'(8 + i), 1'b1);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_16 got %b want 1", full); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL full_empty got %b want 0", empty); end
    push1(5'd31, 1'b0);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_17 got %b want 1", full); end
    tests++; if (tbl_id !== 5'd8) begin fails++; $display("FAIL full_head got %h want 08", tbl_id); end
    mode = 0;
    wait_wid(17, 1500, ok);
    tick(30);
    tests++; if (!ok || wid_q.size() !== 17) begin fails++; $display("FAIL full_plays got %0d want 17", wid_q.size()); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_drained got %b want 1", empty); end
    for (int i = 1; i < gap_q.size(); i++) begin
      tests++; if (gap_q[i] !== 3) begin fails++; $display("FAIL full_gap%0d got %0d want 3", i, gap_q[i]); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0 && wid_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); w = wid_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL full_clip got %h want %h", o, e); end
      tests++; if (w !== 2) begin fails++; $display("FAIL full_width got %0d want 2", w); end
    end
    tests++; if (exp_q.size() !== 0 || obs_q.size() !== 0) begin fails++; $display("FAIL full_left got %0d/%0d want 0/0", obs_q.size(), exp_q.size()); end
    clear_q();
  endtask

  task automatic test_silence();
    bit ok;
    clip_t e, o;
    push1(5'd0, 1'b1);
    push1(5'd2, 1'b1);
    wait_wid(2, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL sil_timeout got %0d pulses want 2", wid_q.size()); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL sil_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL sil_clip got %h want %h", o, e); end
    end
    tick(20);
    clear_q();
  endtask

  task automatic test_timeout();
    bit ok, seen;
    int ecyc;
    clip_t e, o;
    mode = 2;
    push1(5'd5, 1'b1);
    push1(5'd6, 1'b1);
    seen = 1'b0; ecyc = 0;
    for (int i = 0; i < 600; i++) begin
      if (err) begin seen = 1'b1; ecyc = cyc; break; end
      tick(1);
    end
    mode = 0;
    tests++; if (!seen) begin fails++; $display("FAIL tout_err got 0 want 1"); end
    tests++; if (rise_q.size() < 1 || ecyc - rise_q[0] !== ACK_TOUT + 3) begin fails++; $display("FAIL tout_cycles got %0d want %0d", rise_q.size() ? ecyc - rise_q[0] : -1, ACK_TOUT + 3); end
    wait_wid(2, 100, ok);
    tick(20);
    tests++; if (!ok) begin fails++; $display("FAIL tout_next got %0d pulses want 2", wid_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL tout_clip got %h want %h", o, e); end
    end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL tout_sticky got %b want 1", err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tout_idle got %b want 0", busy); end
    clear_q();
  endtask

  task automatic test_abort();
    bit ok;
    do_reset();
    mode = 1;
    push1(5'd9, 1'b1);
    wait_wid(1, 50, ok);
    tick(3);
    for (int i = 0; i < 4; i++) push1(5'(10 + i), 1'b0);
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL abort_pre got %b want 0", empty); end
    abort = 1'b1; push = 1'b1; push_id = 5'd14;
    tick(1);
    abort = 1'b0; push = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL abort_empty got %b want 1", empty); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    tests++; if (start_address !== 24'h009000) begin fails++; $display("FAIL abort_sa got %h want 009000", start_address); end
    tests++; if (end_address !== 24'h009009) begin fails++; $display("FAIL abort_ea got %h want 009009", end_address); end
    mode = 0;
    tick(30);
    tests++; if (wid_q.size() !== 1) begin fails++; $display("FAIL abort_nostart got %0d pulses want 1", wid_q.size()); end
    tests++; if (obs_q.size() > 0 && obs_q[0] !== exp_q[0]) begin fails++; $display("FAIL abort_clip got %h want %h", obs_q[0], exp_q[0]); end
    clear_q();
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    mode = 1;
    push1(5'd9, 1'b1);
    wait_wid(1, 50, ok);
    tick(3);
    for (int i = 0; i < 4; i++) push1(5'(10 + i), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rmid_empty got %b want 1", empty); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
    tests++; if (start_address !== 24'd0) begin fails++; $display("FAIL rmid_sa got %h want 0", start_address); end
    tests++; if (tbl_id !== 5'd0) begin fails++; $display("FAIL rmid_tbl_id got %h want 0", tbl_id); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    mode = 0;
    tick(30);
    tests++; if (wid_q.size() !== 1) begin fails++; $display("FAIL rmid_nostart got %0d pulses want 1", wid_q.size()); end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_two_clips();
    test_full();
    test_silence();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
